axi_crc_framer: RTL and testbench

AXI_CRC_FRAMER -- requirements
Module: axi_crc_framer

---
 rtl/axi_crc_framer.sv | 116 +++++++++++
 tb/tb_axi_crc_framer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crc_framer.sv
// AXI-Stream CRC-16 framer: passes payload bytes through a single output register and
// appends a two-byte CRC (high byte first) after every packet, moving tlast to the CRC
// low byte. Counts packets fully accepted downstream.
module axi_crc_framer #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter logic [15:0] CRC_POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  // upstream payload stream
  input  logic [7:0]  s_axi_tdata,
  input  logic        s_axi_tvalid,
  output logic        s_axi_tready,
  input  logic        s_axi_tlast,
  // downstream framed stream
  output logic [7:0]  m_axi_tdata,
  output logic        m_axi_tvalid,
  input  logic        m_axi_tready,
  output logic        m_axi_tlast,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {StPass, StCrcHi, StCrcLo} state_e;

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        load_en;

  // MSB-first CRC update over one byte, no reflection.
  function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Output register may load when empty or when its current byte is being taken.
  assign load_en      = !m_tvalid_q || m_axi_tready;
  assign s_axi_tready = !rst && (state_q == StPass) && load_en;

  // Next-state, CRC, output register and packet counter.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    pkt_count_d = pkt_count_q;

    if (m_tvalid_q && m_axi_tready && m_tlast_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end

    if (load_en) begin
      unique case (state_q)
        StPass: begin
          if (s_axi_tvalid) begin
            m_tdata_d  = s_axi_tdata;
            m_tlast_d  = 1'b0;
            m_tvalid_d = 1'b1;
            crc_d      = crc_next(crc_q, s_axi_tdata);
            if (s_axi_tlast) state_d = StCrcHi;
          end else begin
            m_tvalid_d = 1'b0;
          end
        end
        StCrcHi: begin
          m_tdata_d  = crc_q[15:8];
          m_tlast_d  = 1'b0;
          m_tvalid_d = 1'b1;
          state_d    = StCrcLo;
        end
        StCrcLo: begin
          m_tdata_d  = crc_q[7:0];
          m_tlast_d  = 1'b1;
          m_tvalid_d = 1'b1;
          crc_d      = CRC_INIT;
          state_d    = StPass;
        end
        default: state_d = StPass;
      endcase
    end
  end

  // State registers with synchronous reset; a reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPass;
      crc_q       <= CRC_INIT;
      m_tdata_q   <= 8'h00;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      pkt_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m_axi_tdata  = m_tdata_q;
  assign m_axi_tvalid = m_tvalid_q;
  assign m_axi_tlast  = m_tlast_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_axi_crc_framer.sv
// Randomized self-checking bench for axi_crc_framer against a packet-level CRC model.
module tb_axi_crc_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_tdata;
  logic        s_axi_tvalid;
  logic        s_axi_tready;
  logic        s_axi_tlast;
  logic [7:0]  m_axi_tdata;
  logic        m_axi_tvalid;
  logic        m_axi_tready;
  logic        m_axi_tlast;
  logic [15:0] pkt_count;

  axi_crc_framer dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_tdata  (s_axi_tdata),
    .s_axi_tvalid (s_axi_tvalid),
    .s_axi_tready (s_axi_tready),
    .s_axi_tlast  (s_axi_tlast),
    .m_axi_tdata  (m_axi_tdata),
    .m_axi_tvalid (m_axi_tvalid),
    .m_axi_tready (m_axi_tready),
    .m_axi_tlast  (m_axi_tlast),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  in_data_q[$];
  bit          in_last_q[$];
  logic [7:0]  exp_data_q[$];
  bit          exp_last_q[$];
  logic [15:0] exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-16 long division over the whole message.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
    logic [15:0] r = 16'hFFFF;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        bit fb = r[15] ^ msg[i][b];
        r = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  function automatic void str2q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // Queue a packet and its expected framed output using the given CRC.
  task automatic add_pkt_crc(input logic [7:0] msg[$], input logic [15:0] crc);
    foreach (msg[i]) begin
      in_data_q.push_back(msg[i]);
      in_last_q.push_back(i == msg.size() - 1);
      exp_data_q.push_back(msg[i]);
      exp_last_q.push_back(1'b0);
    end
    exp_data_q.push_back(crc[15:8]);
    exp_last_q.push_back(1'b0);
    exp_data_q.push_back(crc[7:0]);
    exp_last_q.push_back(1'b1);
    exp_count = exp_count + 16'd1;
  endtask

  task automatic add_pkt(input logic [7:0] msg[$]);
    add_pkt_crc(msg, ref_crc(msg));
  endtask

  // Drive queued input and score output until the expected stream drains.
  task automatic run(input int ready_pct, input int valid_pct, input int max_cycles,
                     input bit check_contig, input int contig_len);
    int       cyc = 0;
    int       first_out = -1;
    int       last_out = -1;
    int       n_out = 0;
    bit       pending = 1'b0;
    bit       stalled = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;
    while (exp_data_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_data", m_axi_tdata, held_data);
        check("stall_last", m_axi_tlast, held_last);
      end
      m_axi_tready = ($urandom_range(99) < ready_pct);
      if (!pending) begin
        s_axi_tvalid = (in_data_q.size() > 0) && ($urandom_range(99) < valid_pct);
      end
      if (in_data_q.size() > 0) begin
        s_axi_tdata = in_data_q[0];
        s_axi_tlast = in_last_q[0];
      end else begin
        s_axi_tdata = 8'($urandom);
        s_axi_tlast = 1'b0;
      end
      #1;
      pending = s_axi_tvalid && !s_axi_tready;
      if (s_axi_tvalid && s_axi_tready) begin
        void'(in_data_q.pop_front());
        void'(in_last_q.pop_front());
      end
      if (m_axi_tvalid && m_axi_tready) begin
        if (exp_data_q.size() > 0) begin
          check("out_data", m_axi_tdata, exp_data_q.pop_front());
          check("out_last", m_axi_tlast, exp_last_q.pop_front());
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      stalled   = m_axi_tvalid && !m_axi_tready;
      held_data = m_axi_tdata;
      held_last = m_axi_tlast;
      cyc++;
    end
    check("drain_timeout", exp_data_q.size(), 0);
    if (check_contig) begin
      check("contig_span", last_out - first_out + 1, contig_len);
      check("contig_count", n_out, contig_len);
    end
    @(negedge clk);
    s_axi_tvalid = 1'b0;
    m_axi_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_out", m_axi_tvalid, 1'b0);
    end
    check("pkt_count", pkt_count, exp_count);
    in_data_q  = {};
    in_last_q  = {};
  endtask

  initial begin
    logic [7:0] msg[$];
    logic [7:0] one[$];
    rst          = 1'b1;
    s_axi_tvalid = 1'b1;
    s_axi_tdata  = 8'hA5;
    s_axi_tlast  = 1'b0;
    m_axi_tready = 1'b1;
    exp_count    = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_tvalid", m_axi_tvalid, 1'b0);
    check("rst_tdata", m_axi_tdata, 8'h00);
    check("rst_tlast", m_axi_tlast, 1'b0);
    check("rst_count", pkt_count, 16'h0000);
    check("rst_sready", s_axi_tready, 1'b0);
    s_axi_tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Check value for the standard string, then a single zero byte.
    str2q("123456789", msg);
    add_pkt_crc(msg, 16'h29B1);
    run(100, 100, 100, 1'b1, 11);
    one = '{8'h00};
    add_pkt_crc(one, 16'hE1F0);
    run(100, 100, 100, 1'b1, 3);

    // Random downstream backpressure.
    add_pkt_crc(msg, 16'h29B1);
    run(50, 100, 500, 1'b0, 0);

    // Back-to-back packets at full rate.
    add_pkt_crc(msg, 16'h29B1);
    add_pkt_crc(msg, 16'h29B1);
    run(100, 100, 100, 1'b1, 22);

    // Random packets, random gaps and backpressure.
    for (int p = 0; p < 12; p++) begin
      int len = $urandom_range(1, 20);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      add_pkt(msg);
    end
    run(60, 70, 3000, 1'b0, 0);

    // Reset in the middle of a packet.
    m_axi_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_axi_tvalid = 1'b1;
      s_axi_tdata  = 8'h31 + 8'(i);
      s_axi_tlast  = 1'b0;
    end
    @(negedge clk);
    s_axi_tvalid = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_sready", s_axi_tready, 1'b0);
    @(negedge clk);
    s_axi_tvalid = 1'b0;
    rst = 1'b0;
    check("mid_rst_tvalid", m_axi_tvalid, 1'b0);
    check("mid_rst_count", pkt_count, 16'h0000);
    exp_count  = 16'h0000;
    exp_data_q = {};
    exp_last_q = {};
    str2q("123456789", msg);
    add_pkt_crc(msg, 16'h29B1);
    run(100, 100, 100, 1'b1, 11);

    // Counter wrap.
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    check("wrap_preload", pkt_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    add_pkt(one);
    run(100, 100, 100, 1'b0, 0);
    check("wrap_zero", pkt_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
